memcpy_job_scheduler: RTL and testbench

- Shares one memcpy engine between NUM_REQ requesters.
- Round-robin arbitration across pending jobs. Latches the winner's src/tgt/len, pulses the engine start, waits for engine done, then returns a per-requester done pulse.
- Sits between the host/action control logic and the memcpy engine's parameter/start/done interface.

---
 rtl/memcpy_job_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_memcpy_job_scheduler.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memcpy_job_scheduler.sv
// Round-robin scheduler sharing one memcpy engine between NUM_REQ requesters.
// Optional watchdog abort enabled by defining MEMCPY_SCHED_TIMEOUT_EN.
`timescale 1ns/1ps
module memcpy_job_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_src_addr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_tgt_addr,
  input  logic [NUM_REQ*64-1:0]         req_len,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [NUM_REQ-1:0]            req_done,
  output logic                          req_err,
  output logic [ADDR_WIDTH-1:0]         memcpy_src_addr,
  output logic [ADDR_WIDTH-1:0]         memcpy_tgt_addr,
  output logic [63:0]                   memcpy_len,
  output logic                          memcpy_start,
  input  logic                          memcpy_done,
  output logic                          sched_busy,
  output logic [2:0]                    cur_grant
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("memcpy_job_scheduler: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_START, S_CLR, S_WAIT, S_RETIRE
  } state_t;

  state_t state, state_nxt;

  logic [2:0]            last_q;
  logic [2:0]            pick;
  logic                  pick_vld;
  logic [IW-1:0]         idx;
  int                    sum;
  logic [NUM_REQ-1:0]    grant_oh;
  logic [ADDR_WIDTH-1:0] sel_src;
  logic [ADDR_WIDTH-1:0] sel_tgt;
  logic [63:0]           sel_len;

  // Requester i is considered at distance (i - last) mod NUM_REQ; nearest pending wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    sum      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = int'(last_q) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = IW'(sum);
      if (!pick_vld && req_valid[idx]) begin
        pick_vld = 1'b1;
        pick     = 3'(idx);
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    sel_src  = '0;
    sel_tgt  = '0;
    sel_len  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (cur_grant == 3'(i)) begin
        grant_oh[i] = 1'b1;
        sel_src     = req_src_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_tgt     = req_tgt_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len     = req_len[i*64 +: 64];
      end
    end
  end

`ifdef MEMCPY_SCHED_TIMEOUT_EN
  localparam logic [31:0] WD_LIMIT = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] wd_cnt;
  logic        wd_hit;
  logic        tmo_exit;
  logic        timed_out_q;

  assign wd_hit = (wd_cnt >= WD_LIMIT);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // CLR drains the done level left high by the previous job before WAIT looks for a fresh rise.
  always_comb begin
    state_nxt = state;
`ifdef MEMCPY_SCHED_TIMEOUT_EN
    tmo_exit  = 1'b0;
`endif
    case (state)
      S_IDLE:   if (pick_vld) state_nxt = S_LATCH;
      S_LATCH:  state_nxt = (sel_len == 64'd0) ? S_RETIRE : S_START;
      S_START:  state_nxt = S_CLR;
      S_CLR: begin
`ifdef MEMCPY_SCHED_TIMEOUT_EN
        if (wd_hit) begin
          state_nxt = S_RETIRE;
          tmo_exit  = 1'b1;
        end else
`endif
        if (!memcpy_done) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (memcpy_done) state_nxt = S_RETIRE;
`ifdef MEMCPY_SCHED_TIMEOUT_EN
        else if (wd_hit) begin
          state_nxt = S_RETIRE;
          tmo_exit  = 1'b1;
        end
`endif
      end
      S_RETIRE: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_grant       <= '0;
      last_q          <= 3'(NUM_REQ - 1);
      req_ack         <= '0;
      memcpy_src_addr <= '0;
      memcpy_tgt_addr <= '0;
      memcpy_len      <= '0;
    end else begin
      req_ack <= '0;
      case (state)
        S_IDLE: if (pick_vld) cur_grant <= pick;
        S_LATCH: begin
          memcpy_src_addr <= sel_src;
          memcpy_tgt_addr <= sel_tgt;
          memcpy_len      <= sel_len;
          req_ack         <= grant_oh;
          last_q          <= cur_grant;
        end
        default: ;
      endcase
    end
  end

`ifdef MEMCPY_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt      <= '0;
      timed_out_q <= 1'b0;
    end else begin
      case (state)
        S_START: begin
          wd_cnt      <= '0;
          timed_out_q <= 1'b0;
        end
        S_CLR, S_WAIT: begin
          wd_cnt <= wd_cnt + 32'd1;
          if (tmo_exit) timed_out_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign req_err = (state == S_RETIRE) && timed_out_q;
`else
  assign req_err = 1'b0;
`endif

  assign memcpy_start = (state == S_START);
  assign sched_busy   = (state != S_IDLE);
  assign req_done     = (state == S_RETIRE) ? grant_oh : '0;

endmodule

// File: tb/tb_memcpy_job_scheduler.sv
// Self-checking bench for memcpy_job_scheduler: engine model, requester agent,
// round-robin reference model and per-scenario tests.
`timescale 1ns/1ps
module tb_memcpy_job_scheduler;
  localparam int NUM_REQ = 4;
  localparam int AW      = 64;
`ifdef MEMCPY_SCHED_TIMEOUT_EN
  localparam int TMO = 100;
`else
  localparam int TMO = 1048576;
`endif
  localparam int OW = 2*NUM_REQ + 6 + 2*AW + 64;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ*AW-1:0] req_src_addr = '0;
  logic [NUM_REQ*AW-1:0] req_tgt_addr = '0;
  logic [NUM_REQ*64-1:0] req_len = '0;
  logic [NUM_REQ-1:0]    req_ack, req_done;
  logic                  req_err, memcpy_start, sched_busy;
  logic [AW-1:0]         memcpy_src_addr, memcpy_tgt_addr;
  logic [63:0]           memcpy_len;
  logic                  memcpy_done = 1'b0;
  logic [2:0]            cur_grant;
  logic [OW-1:0]         all_outs;

  memcpy_job_scheduler #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_src_addr(req_src_addr),
    .req_tgt_addr(req_tgt_addr), .req_len(req_len), .req_ack(req_ack), .req_done(req_done),
    .req_err(req_err), .memcpy_src_addr(memcpy_src_addr), .memcpy_tgt_addr(memcpy_tgt_addr),
    .memcpy_len(memcpy_len), .memcpy_start(memcpy_start), .memcpy_done(memcpy_done),
    .sched_busy(sched_busy), .cur_grant(cur_grant)
  );

  assign all_outs = {req_ack, req_done, req_err, memcpy_start, sched_busy, cur_grant,
                     memcpy_src_addr, memcpy_tgt_addr, memcpy_len};

  // ---------------- clock / reset / global limit ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run = 0;
  int tests_failed = 0;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, failed=%0d", tests_failed);
    $fatal(1, "global time limit");
  end

  // ---------------- monitor logs ----------------
  int            ack_q[$], ack_cyc_q[$], done_q[$], done_cyc_q[$], st_cyc_q[$];
  logic          done_err_q[$];
  logic [AW-1:0] st_src_q[$], st_tgt_q[$];
  logic [63:0]   st_len_q[$];

  function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
    int n = 0, r = -1;
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) begin n++; r = i; end
    return (n == 1) ? r : -1;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (|req_ack) begin ack_q.push_back(onehot_idx(req_ack)); ack_cyc_q.push_back(cyc); end
      if (|req_done) begin
        done_q.push_back(onehot_idx(req_done));
        done_cyc_q.push_back(cyc);
        done_err_q.push_back(req_err);
      end
      if (memcpy_start) begin
        st_src_q.push_back(memcpy_src_addr);
        st_tgt_q.push_back(memcpy_tgt_addr);
        st_len_q.push_back(memcpy_len);
        st_cyc_q.push_back(cyc);
      end
    end
  end

  function automatic void clear_logs();
    ack_q.delete(); ack_cyc_q.delete(); done_q.delete(); done_cyc_q.delete();
    done_err_q.delete(); st_src_q.delete(); st_tgt_q.delete(); st_len_q.delete();
    st_cyc_q.delete();
  endfunction

  // ---------------- memcpy engine model ----------------
  int eng_stale = 0, eng_lat = 10, eng_cnt = 0, rise_cyc = 0;
  bit eng_run = 1'b0;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        eng_run = 1'b0; memcpy_done = 1'b0;
      end else if (memcpy_start) begin
        eng_run = 1'b1; eng_cnt = 0;
        if (eng_stale == 0) memcpy_done = 1'b0;
      end else if (eng_run) begin
        eng_cnt++;
        if (eng_cnt == eng_stale) memcpy_done = 1'b0;
        if (eng_cnt == eng_stale + eng_lat) begin
          memcpy_done = 1'b1; eng_run = 1'b0; rise_cyc = cyc;
        end
      end
    end
  end

  // ---------------- requester agent: drop after ack, re-raise after done ----------------
  int rerun[NUM_REQ];
  logic [NUM_REQ-1:0] ack_prev = '0;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!rst_n) ack_prev = '0;
      else begin
        logic [NUM_REQ-1:0] raised;
        raised = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (ack_prev[i]) req_valid[i] = 1'b0;
          if (req_done[i] && rerun[i] > 0) begin
            req_valid[i] = 1'b1; rerun[i]--; raised[i] = 1'b1;
          end
        end
        ack_prev = req_ack & ~raised;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [2:0] exp_q[$];
  int model_last = NUM_REQ - 1;

  function automatic void model_order(input logic [NUM_REQ-1:0] pend_in, input int rr_in[NUM_REQ]);
    logic [NUM_REQ-1:0] pend = pend_in;
    int rr[NUM_REQ] = rr_in;
    while (pend != '0) begin
      int c = -1;
      for (int k = 1; k <= NUM_REQ; k++) begin
        int t = (model_last + k) % NUM_REQ;
        if (c < 0 && pend[t]) c = t;
      end
      exp_q.push_back(3'(c));
      model_last = c;
      if (rr[c] > 0) rr[c]--;
      else pend[c] = 1'b0;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_job(input int i, input logic [AW-1:0] s, input logic [AW-1:0] t, input logic [63:0] l);
    req_src_addr[i*AW +: AW] = s;
    req_tgt_addr[i*AW +: AW] = t;
    req_len[i*64 +: 64]      = l;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    req_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) rerun[i] = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    model_last = NUM_REQ - 1;
    exp_q.delete();
    clear_logs();
  endtask

  task automatic raise(input logic [NUM_REQ-1:0] mask, output int v);
    @(posedge clk); #2;
    v = cyc;
    req_valid = req_valid | mask;
  endtask

  task automatic wait_done(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk); #1;
      if (done_q.size() >= n && !sched_busy && req_valid == '0) begin ok = 1'b1; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; #1;
    tests_run++;
    if (all_outs !== '0) begin tests_failed++; $display("FAIL reset_outputs: got %h expected 0", all_outs); end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (all_outs !== '0) begin tests_failed++; $display("FAIL idle_after_reset: got %h expected 0", all_outs); end
    clear_logs();
  endtask

  task automatic test_single_job();
    int v; bit ok; int rr[NUM_REQ] = '{default: 0};
    reset_dut();
    eng_stale = 0; eng_lat = 50;
    set_job(0, 64'h1000, 64'h2000, 64'h200);
    model_order(4'b0001, rr);
    raise(4'b0001, v);
    wait_done(1, 300, ok);
    tests_run++;
    if (ok !== 1'b1) begin tests_failed++; $display("FAIL single_wait: got %0d done expected 1", done_q.size()); end
    tests_run++;
    if (ack_q.size() != 1 || ack_q[0] != 0 || ack_cyc_q[0] - v != 2) begin
      tests_failed++; $display("FAIL single_ack: got %0d acks latency %0d expected 1 ack latency 2",
                               ack_q.size(), (ack_cyc_q.size() > 0) ? ack_cyc_q[0] - v : -1);
    end
    tests_run++;
    if (st_len_q.size() != 1 || {st_src_q[0], st_tgt_q[0], st_len_q[0]} !== {64'h1000, 64'h2000, 64'h200}) begin
      tests_failed++; $display("FAIL single_start: got %0d starts expected 1 with 1000/2000/200", st_len_q.size());
    end
    tests_run++;
    if (done_q.size() != 1 || done_q[0] != 0 || done_err_q[0] !== 1'b0 || done_cyc_q[0] != rise_cyc + 1) begin
      tests_failed++; $display("FAIL single_done: got %0d dones at cyc %0d expected 1 at %0d err 0",
                               done_q.size(), (done_cyc_q.size() > 0) ? done_cyc_q[0] : -1, rise_cyc + 1);
    end
    exp_q.delete();
  endtask

  task automatic check_order(input string name);
    tests_run++;
    if (ack_q.size() != exp_q.size() || done_q.size() != exp_q.size()) begin
      tests_failed++; $display("FAIL %s_count: got %0d acks %0d dones expected %0d",
                               name, ack_q.size(), done_q.size(), exp_q.size());
    end
    for (int j = 0; j < exp_q.size() && j < ack_q.size() && j < done_q.size(); j++) begin
      tests_run++;
      if (ack_q[j] != int'(exp_q[j]) || done_q[j] != int'(exp_q[j]) || done_err_q[j] !== 1'b0) begin
        tests_failed++; $display("FAIL %s_order[%0d]: got ack %0d done %0d expected %0d",
                                 name, j, ack_q[j], done_q[j], exp_q[j]);
      end
    end
  endtask

  task automatic test_contention();
    int v; bit ok; int rr[NUM_REQ] = '{1, 0, 0, 0};
    reset_dut();
    eng_stale = 0; eng_lat = $urandom_range(2, 12);
    for (int i = 0; i < NUM_REQ; i++) begin
      set_job(i, 64'($urandom), 64'($urandom), 64'($urandom_range(1, 4096)));
      rerun[i] = rr[i];
    end
    model_order(4'b1111, rr);
    raise(4'b1111, v);
    wait_done(5, 500, ok);
    tests_run++;
    if (ok !== 1'b1) begin tests_failed++; $display("FAIL contention_wait: got %0d dones expected 5", done_q.size()); end
    check_order("contention");
    tests_run++;
    if (st_len_q.size() != 5) begin tests_failed++; $display("FAIL contention_starts: got %0d expected 5", st_len_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_zero_len();
    int v; bit ok; int rr[NUM_REQ] = '{default: 0};
    clear_logs();
    set_job(2, 64'hAAAA, 64'hBBBB, 64'h0);
    model_order(4'b0100, rr);
    raise(4'b0100, v);
    wait_done(1, 50, ok);
    tests_run++;
    if (ok !== 1'b1) begin tests_failed++; $display("FAIL zero_wait: got %0d dones expected 1", done_q.size()); end
    check_order("zero");
    tests_run++;
    if (ack_cyc_q.size() != 1 || done_cyc_q.size() != 1 || ack_cyc_q[0] - v != 2 ||
        done_cyc_q[0] < ack_cyc_q[0] || done_cyc_q[0] - ack_cyc_q[0] > 3) begin
      tests_failed++; $display("FAIL zero_timing: got %0d acks %0d dones expected ack at +2 then done within 3",
                               ack_cyc_q.size(), done_cyc_q.size());
    end
    tests_run++;
    if (st_len_q.size() != 0) begin tests_failed++; $display("FAIL zero_no_start: got %0d starts expected 0", st_len_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_stale_done();
    int v; bit ok; int rr[NUM_REQ] = '{default: 0};
    clear_logs();
    eng_stale = 0; eng_lat = 5;
    set_job(1, 64'h40, 64'h80, 64'h40);
    model_order(4'b0010, rr);
    raise(4'b0010, v);
    wait_done(1, 100, ok);
    tests_run++;
    if (ok !== 1'b1 || memcpy_done !== 1'b1) begin
      tests_failed++; $display("FAIL stale_setup: got ok %0d done level %0d expected 1 1", ok, memcpy_done);
    end
    eng_stale = 5; eng_lat = 20;
    set_job(3, 64'hDEAD0000, 64'hBEEF0000, 64'h1234);
    model_order(4'b1000, rr);
    raise(4'b1000, v);
    wait_done(2, 200, ok);
    tests_run++;
    if (ok !== 1'b1) begin tests_failed++; $display("FAIL stale_wait: got %0d dones expected 2", done_q.size()); end
    check_order("stale");
    tests_run++;
    if (done_cyc_q.size() != 2 || st_cyc_q.size() != 2 || done_cyc_q[1] != rise_cyc + 1 ||
        done_cyc_q[1] - st_cyc_q[1] != 26) begin
      tests_failed++; $display("FAIL stale_latency: got done-start %0d expected 26",
                               (done_cyc_q.size() == 2 && st_cyc_q.size() == 2) ? done_cyc_q[1] - st_cyc_q[1] : -1);
    end
    exp_q.delete();
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int v, nz; bit ok; int rr[NUM_REQ];
      logic [NUM_REQ-1:0] pend;
      logic [AW-1:0] js[NUM_REQ], jt[NUM_REQ];
      logic [63:0] jl[NUM_REQ];
      clear_logs();
      eng_stale = $urandom_range(0, 4); eng_lat = $urandom_range(2, 20);
      pend = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      for (int i = 0; i < NUM_REQ; i++) begin
        js[i] = {32'($urandom), 32'($urandom)};
        jt[i] = {32'($urandom), 32'($urandom)};
        jl[i] = ($urandom_range(0, 3) == 0) ? 64'd0 : 64'($urandom_range(1, 65535));
        rr[i] = pend[i] ? $urandom_range(0, 2) : 0;
        rerun[i] = rr[i];
        set_job(i, js[i], jt[i], jl[i]);
      end
      model_order(pend, rr);
      raise(pend, v);
      wait_done(exp_q.size(), 1500, ok);
      tests_run++;
      if (ok !== 1'b1) begin tests_failed++; $display("FAIL random_wait[%0d]: got %0d dones expected %0d", it, done_q.size(), exp_q.size()); end
      check_order("random");
      nz = 0;
      for (int j = 0; j < exp_q.size(); j++) begin
        if (jl[exp_q[j]] != 64'd0) begin
          tests_run++;
          if (nz >= st_len_q.size() ||
              {st_src_q[nz], st_tgt_q[nz], st_len_q[nz]} !== {js[exp_q[j]], jt[exp_q[j]], jl[exp_q[j]]}) begin
            tests_failed++; $display("FAIL random_params[%0d.%0d]: got start %0d of %0d expected params of req %0d",
                                     it, j, nz, st_len_q.size(), exp_q[j]);
          end
          nz++;
        end
      end
      tests_run++;
      if (st_len_q.size() != nz) begin tests_failed++; $display("FAIL random_starts[%0d]: got %0d expected %0d", it, st_len_q.size(), nz); end
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_job();
    int v; bit ok; int rr[NUM_REQ] = '{default: 0};
    reset_dut();
    eng_stale = 0; eng_lat = 100000;
    set_job(1, 64'h10, 64'h20, 64'h30);
    raise(4'b0010, v);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (st_cyc_q.size() > 0) begin ok = 1'b1; break; end
    end
    tests_run++;
    if (ok !== 1'b1) begin tests_failed++; $display("FAIL midreset_start: got no start expected one"); end
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    tests_run++;
    if (all_outs !== '0) begin tests_failed++; $display("FAIL midreset_outputs: got %h expected 0", all_outs); end
    repeat (2) @(posedge clk);
    eng_lat = 4;
    #2 rst_n = 1'b1;
    tests_run++;
    if (done_q.size() != 0) begin tests_failed++; $display("FAIL midreset_no_done: got %0d expected 0", done_q.size()); end
    model_last = NUM_REQ - 1;
    exp_q.delete();
    clear_logs();
    for (int i = 0; i < NUM_REQ; i++) set_job(i, 64'(i + 1), 64'(i + 9), 64'(16 * (i + 1)));
    model_order(4'b1111, rr);
    raise(4'b1111, v);
    wait_done(4, 300, ok);
    tests_run++;
    if (ok !== 1'b1) begin tests_failed++; $display("FAIL midreset_wait: got %0d dones expected 4", done_q.size()); end
    check_order("midreset");
    exp_q.delete();
  endtask

`ifdef MEMCPY_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int v; bit ok;
    reset_dut();
    eng_stale = 0; eng_lat = 100000;
    set_job(0, 64'h100, 64'h200, 64'h300);
    raise(4'b0001, v);
    wait_done(1, 300, ok);
    tests_run++;
    if (ok !== 1'b1) begin tests_failed++; $display("FAIL timeout_wait: got %0d dones expected 1", done_q.size()); end
    tests_run++;
    if (done_q.size() != 1 || st_cyc_q.size() != 1 || done_err_q[0] !== 1'b1 || done_q[0] != 0 ||
        done_cyc_q[0] - (st_cyc_q[0] + 1) != TMO) begin
      tests_failed++; $display("FAIL timeout_done: got %0d dones expected one with err=1 at CLR+%0d", done_q.size(), TMO);
    end
    reset_dut();
  endtask
`endif

  initial begin
    for (int i = 0; i < NUM_REQ; i++) rerun[i] = 0;
    test_reset();
    test_single_job();
    test_contention();
    test_zero_len();
    test_stale_done();
    test_random();
    test_reset_mid_job();
`ifdef MEMCPY_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
